// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM state encoding, ALU-op / mux-select encodings and dispatch helpers for multicycle_control
package mc_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SRL   = 6'h06;
   localparam logic [5:0] OP_SLL   = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LI    = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_SLT   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_FUNCT = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_NONE  = 3'b111;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] BSRC_B     = 2'd0;
   localparam logic [1:0] BSRC_4     = 2'd1;
   localparam logic [1:0] BSRC_IMM   = 2'd2;
   localparam logic [1:0] BSRC_SHIMM = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTEXE    = 4'd6,
      S_RTWB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMMEXE   = 4'd10,
      S_IMMWB    = 4'd11,
      S_SHIFTEXE = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   // DECODE successor; unknown opcodes map to S_TRAP and the caller decides NOP vs trap
   function automatic state_t dispatch(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:                             return S_MEMADR;
         OP_RTYPE:                                 return S_RTEXE;
         OP_BEQ, OP_BNE:                           return S_BRANCH;
         OP_J, OP_JAL:                             return S_JUMP;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LI: return S_IMMEXE;
         OP_SRL, OP_SLL:                           return S_SHIFTEXE;
         default:                                  return S_TRAP;
      endcase
   endfunction

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      return (op == OP_ADDI) ? ALU_ADD :
             (op == OP_SLTI) ? ALU_SLT :
             (op == OP_ANDI) ? ALU_AND :
             (op == OP_ORI)  ? ALU_OR  : ALU_NONE;
   endfunction
endpackage

// File: rtl/mc_aluop_decode.sv
// mc_aluop_decode: maps FSM state and latched opcode to the ALU control class
import mc_pkg::*;

module mc_aluop_decode #(
   parameter int ALUOP_W = 3
) (
   input  state_t             state,
   input  logic [5:0]         opcode_q,
   output logic [ALUOP_W-1:0] alu_op
);
   assign alu_op = (state == S_FETCH || state == S_DECODE || state == S_MEMADR) ? ALU_ADD :
                   (state == S_BRANCH) ? ALU_SUB   :
                   (state == S_RTEXE)  ? ALU_FUNCT :
                   (state == S_IMMEXE) ? imm_alu_op(opcode_q) : ALU_NONE;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the shared-memory multi-cycle MIPS-subset datapath; MULTICYCLE_ILLEGAL_TRAP_EN enables the illegal-opcode trap
import mc_pkg::*;

module multicycle_control #(
   parameter int OPCODE_W = 6,
   parameter int ALUOP_W  = 3,
   parameter int COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               bne,
   output logic [1:0]         pc_src,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               shift,
   output logic               sll,
   output logic               jal,
   output logic               trap,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instr_count
);
   state_t cur, nxt, dec;
   logic [OPCODE_W-1:0] opcode_q;

   assign state = cur;
   assign dec = dispatch(opcode);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   assign trap = (cur == S_TRAP);
`else
   assign trap = 1'b0;
`endif

   mc_aluop_decode #(.ALUOP_W(ALUOP_W)) u_aluop (
      .state(cur),
      .opcode_q(opcode_q),
      .alu_op(alu_op)
   );

   // state, latched opcode and retire counter; retirement is any return to FETCH from elsewhere
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cur         <= S_FETCH;
         opcode_q    <= '0;
         instr_count <= '0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE) opcode_q <= opcode;
         if (nxt == S_FETCH && cur != S_FETCH) instr_count <= instr_count + 1'b1;
      end

   // next state and Moore outputs; FETCH gates its loads on mem_ready so a stalled fetch is harmless
   always_comb begin
      nxt           = cur;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      bne           = 1'b0;
      pc_src        = PC_ALU;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = BSRC_B;
      shift         = 1'b0;
      sll           = 1'b0;
      jal           = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            alu_src_b = BSRC_4;
            nxt       = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = BSRC_SHIMM;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            nxt       = dec;
`else
            nxt       = (dec == S_TRAP) ? S_FETCH : dec;
`endif
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = BSRC_IMM;
            nxt       = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            nxt      = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            nxt        = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            nxt       = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_RTEXE: begin
            alu_src_a = 1'b1;
            nxt       = S_RTWB;
         end
         S_RTWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            nxt       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            pc_write_cond = 1'b1;
            pc_src        = PC_ALUOUT;
            bne           = (opcode_q == OP_BNE);
            nxt           = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_src    = PC_JUMP;
            jal       = (opcode_q == OP_JAL);
            reg_write = (opcode_q == OP_JAL);
            nxt       = S_FETCH;
         end
         S_IMMEXE: begin
            alu_src_a = 1'b1;
            alu_src_b = BSRC_IMM;
            nxt       = S_IMMWB;
         end
         S_IMMWB: begin
            reg_write = 1'b1;
            nxt       = S_FETCH;
         end
         S_SHIFTEXE: begin
            shift     = 1'b1;
            sll       = (opcode_q == OP_SLL);
            alu_src_a = 1'b1;
            nxt       = S_RTWB;
         end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
         S_TRAP: nxt = S_TRAP;
`endif
         default: nxt = S_FETCH;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control; honours MULTICYCLE_ILLEGAL_TRAP_EN
module tb_multicycle_control;
   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, shift, sll, jal, trap;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .bne(bne), .pc_src(pc_src),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .shift(shift), .sll(sll), .jal(jal), .trap(trap), .state(state),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // control word: {pc_write,pc_write_cond,bne}, pc_src, {iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a}, alu_src_b, alu_op, {shift,sll,jal,trap}
   logic [21:0] act;
   assign act = {pc_write, pc_write_cond, bne, pc_src, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, shift, sll, jal, trap};

   localparam logic [21:0] C_FETCH  = {3'b100, 2'd0, 8'b0101_0000, 2'd1, 3'b000, 4'b0000};
   localparam logic [21:0] C_FWAIT  = {3'b000, 2'd0, 8'b0100_0000, 2'd1, 3'b000, 4'b0000};
   localparam logic [21:0] C_DEC    = {3'b000, 2'd0, 8'b0000_0000, 2'd3, 3'b000, 4'b0000};
   localparam logic [21:0] C_MEMADR = {3'b000, 2'd0, 8'b0000_0001, 2'd2, 3'b000, 4'b0000};
   localparam logic [21:0] C_MEMRD  = {3'b000, 2'd0, 8'b1100_0000, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_MEMWB  = {3'b000, 2'd0, 8'b0000_0110, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_MEMWR  = {3'b000, 2'd0, 8'b1010_0000, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_RTEXE  = {3'b000, 2'd0, 8'b0000_0001, 2'd0, 3'b100, 4'b0000};
   localparam logic [21:0] C_RTWB   = {3'b000, 2'd0, 8'b0000_1010, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_BEQ    = {3'b010, 2'd1, 8'b0000_0001, 2'd0, 3'b001, 4'b0000};
   localparam logic [21:0] C_BNE    = {3'b011, 2'd1, 8'b0000_0001, 2'd0, 3'b001, 4'b0000};
   localparam logic [21:0] C_J      = {3'b100, 2'd2, 8'b0000_0000, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_JAL    = {3'b100, 2'd2, 8'b0000_0010, 2'd0, 3'b111, 4'b0010};
   localparam logic [21:0] C_IMMWB  = {3'b000, 2'd0, 8'b0000_0010, 2'd0, 3'b111, 4'b0000};
   localparam logic [21:0] C_SLL    = {3'b000, 2'd0, 8'b0000_0001, 2'd0, 3'b111, 4'b1100};
   localparam logic [21:0] C_SRL    = {3'b000, 2'd0, 8'b0000_0001, 2'd0, 3'b111, 4'b1000};
   localparam logic [21:0] C_TRAP   = {3'b000, 2'd0, 8'b0000_0000, 2'd0, 3'b111, 4'b0001};

   function automatic logic [21:0] c_imm(input logic [2:0] aop);
      return {3'b000, 2'd0, 8'b0000_0001, 2'd2, aop, 4'b0000};
   endfunction

   typedef struct packed {
      int          id;
      logic [3:0]  st;
      logic [21:0] c;
      logic [31:0] n;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          id = 0;
   int          vecs = 0;
   int          errs = 0;
   logic [31:0] ecnt = 0;

   // monitor: every queued expectation is checked at the falling edge of its cycle
   always @(negedge clk)
      if (q.size() != 0) begin
         me = q.pop_front();
         vecs++;
         if (state !== me.st || act !== me.c || instr_count !== me.n) begin
            errs++;
            $display("FAIL vec%0d: got state=%0d ctrl=%h count=%0d, want state=%0d ctrl=%h count=%0d",
                     me.id, state, act, instr_count, me.st, me.c, me.n);
         end
      end

   task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] s, input logic [21:0] c);
      opcode    = op;
      mem_ready = rdy;
      q.push_back(exp_t'{id, s, c, ecnt});
      id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      opcode    = 6'h00;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step(6'h00, 1'b0, 4'd0, C_FWAIT);
      reset = 1'b0;
      // stalled fetch does not retire
      step(6'h23, 1'b0, 4'd0, C_FWAIT);
      // LW: 0,1,2,3,4
      step(6'h23, 1'b1, 4'd0, C_FETCH);
      step(6'h23, 1'b1, 4'd1, C_DEC);
      step(6'h23, 1'b1, 4'd2, C_MEMADR);
      step(6'h23, 1'b1, 4'd3, C_MEMRD);
      step(6'h23, 1'b1, 4'd4, C_MEMWB);
      ecnt++;
      // SW with three wait cycles in MEMWR
      step(6'h2b, 1'b1, 4'd0, C_FETCH);
      step(6'h2b, 1'b1, 4'd1, C_DEC);
      step(6'h2b, 1'b1, 4'd2, C_MEMADR);
      step(6'h2b, 1'b0, 4'd5, C_MEMWR);
      step(6'h2b, 1'b0, 4'd5, C_MEMWR);
      step(6'h2b, 1'b0, 4'd5, C_MEMWR);
      step(6'h2b, 1'b1, 4'd5, C_MEMWR);
      ecnt++;
      // BNE, BEQ, JAL, J
      step(6'h05, 1'b1, 4'd0, C_FETCH);
      step(6'h05, 1'b1, 4'd1, C_DEC);
      step(6'h05, 1'b1, 4'd8, C_BNE);
      ecnt++;
      step(6'h04, 1'b1, 4'd0, C_FETCH);
      step(6'h04, 1'b1, 4'd1, C_DEC);
      step(6'h04, 1'b1, 4'd8, C_BEQ);
      ecnt++;
      step(6'h03, 1'b1, 4'd0, C_FETCH);
      step(6'h03, 1'b1, 4'd1, C_DEC);
      step(6'h03, 1'b1, 4'd9, C_JAL);
      ecnt++;
      step(6'h02, 1'b1, 4'd0, C_FETCH);
      step(6'h02, 1'b1, 4'd1, C_DEC);
      step(6'h02, 1'b1, 4'd9, C_J);
      ecnt++;
      // R-type
      step(6'h00, 1'b1, 4'd0, C_FETCH);
      step(6'h00, 1'b1, 4'd1, C_DEC);
      step(6'h00, 1'b1, 4'd6, C_RTEXE);
      step(6'h00, 1'b1, 4'd7, C_RTWB);
      ecnt++;
      // immediates: ORI 101, ADDI 000, SLTI 010, ANDI 011, LI 111
      step(6'h0d, 1'b1, 4'd0, C_FETCH);
      step(6'h0d, 1'b1, 4'd1, C_DEC);
      step(6'h0d, 1'b1, 4'd10, c_imm(3'b101));
      step(6'h0d, 1'b1, 4'd11, C_IMMWB);
      ecnt++;
      step(6'h08, 1'b1, 4'd0, C_FETCH);
      step(6'h08, 1'b1, 4'd1, C_DEC);
      step(6'h08, 1'b1, 4'd10, c_imm(3'b000));
      step(6'h08, 1'b1, 4'd11, C_IMMWB);
      ecnt++;
      step(6'h0a, 1'b1, 4'd0, C_FETCH);
      step(6'h0a, 1'b1, 4'd1, C_DEC);
      step(6'h0a, 1'b1, 4'd10, c_imm(3'b010));
      step(6'h0a, 1'b1, 4'd11, C_IMMWB);
      ecnt++;
      step(6'h0c, 1'b1, 4'd0, C_FETCH);
      step(6'h0c, 1'b1, 4'd1, C_DEC);
      step(6'h0c, 1'b1, 4'd10, c_imm(3'b011));
      step(6'h0c, 1'b1, 4'd11, C_IMMWB);
      ecnt++;
      step(6'h0f, 1'b1, 4'd0, C_FETCH);
      step(6'h0f, 1'b1, 4'd1, C_DEC);
      step(6'h0f, 1'b1, 4'd10, c_imm(3'b111));
      step(6'h0f, 1'b1, 4'd11, C_IMMWB);
      ecnt++;
      // shifts go through RTWB
      step(6'h07, 1'b1, 4'd0, C_FETCH);
      step(6'h07, 1'b1, 4'd1, C_DEC);
      step(6'h07, 1'b1, 4'd12, C_SLL);
      step(6'h07, 1'b1, 4'd7, C_RTWB);
      ecnt++;
      step(6'h06, 1'b1, 4'd0, C_FETCH);
      step(6'h06, 1'b1, 4'd1, C_DEC);
      step(6'h06, 1'b1, 4'd12, C_SRL);
      step(6'h06, 1'b1, 4'd7, C_RTWB);
      ecnt++;
      // unknown opcode 0x3f
      step(6'h3f, 1'b1, 4'd0, C_FETCH);
      step(6'h3f, 1'b1, 4'd1, C_DEC);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      step(6'h00, 1'b1, 4'd13, C_TRAP);
      step(6'h00, 1'b1, 4'd13, C_TRAP);
      step(6'h00, 1'b1, 4'd13, C_TRAP);
      reset = 1'b1;
      ecnt  = 0;
      step(6'h00, 1'b0, 4'd0, C_FWAIT);
      reset = 1'b0;
`else
      ecnt++;
      step(6'h00, 1'b0, 4'd0, C_FWAIT);
`endif
      // asynchronous reset while stalled in MEMWR
      step(6'h2b, 1'b1, 4'd0, C_FETCH);
      step(6'h2b, 1'b1, 4'd1, C_DEC);
      step(6'h2b, 1'b1, 4'd2, C_MEMADR);
      step(6'h2b, 1'b0, 4'd5, C_MEMWR);
      reset = 1'b1;
      ecnt  = 0;
      step(6'h2b, 1'b0, 4'd0, C_FWAIT);
      reset = 1'b0;
      step(6'h23, 1'b1, 4'd0, C_FETCH);
      step(6'h23, 1'b1, 4'd1, C_DEC);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several clocks for the same MIPS-subset ISA.
- Drives the shared-memory multi-cycle datapath: PC, IR, register file, ALU and unified instruction/data memory.
- Adds a memory ready handshake, a retired-instruction counter and an optional illegal-opcode trap.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 3, width of alu_op to the ALU control.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the branch condition holds.
- bne  out  1  inverts the branch condition (zero flag).
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source: 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- alu_op  out  ALUOP_W  ALU control class.
- shift  out  1  shifter path select.
- sll  out  1  shift left (1) / right (0).
- jal  out  1  write PC+4 to $31.
- trap  out  1  illegal opcode trap.
- state  out  4  current state, for debug.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- Opcodes: RTYPE 0x00, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, SRL 0x06, SLL 0x07, ADDI 0x08, SLTI 0x0a, ANDI 0x0c, ORI 0x0d, LI 0x0f, LW 0x23, SW 0x2b.
- alu_op encoding: 000 add, 001 sub, 010 slt, 011 and, 100 funct-decoded, 101 or, 111 pass/none.
- Reset (async): state = FETCH, instr_count = 0, opcode_q = 0, trap = 0. All outputs take their FETCH Moore values from the cycle reset is released.
- Outputs are a combinational function of state and opcode_q only. opcode_q latches opcode in DECODE. Any output not listed for a state is 0; alu_op defaults to 111.
- States and transitions:
  - FETCH(0): mem_read, ir_write, pc_write, alu_src_b=1, alu_op=000, iord=0. Stays while mem_ready=0; in that case ir_write and pc_write are forced to 0. On mem_ready=1 -> DECODE.
  - DECODE(1): alu_src_b=3, alu_op=000 (branch target).
    - LW/SW -> MEMADR; RTYPE -> RTEXE; BEQ/BNE -> BRANCH; J/JAL -> JUMP.
    - ADDI/SLTI/ANDI/ORI/LI -> IMMEXE; SRL/SLL -> SHIFTEXE.
    - Any other opcode -> FETCH (NOP).
  - MEMADR(2): alu_src_a=1, alu_src_b=2, alu_op=000. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(3): mem_read, iord=1. Waits on mem_ready, then -> MEMWB.
  - MEMWB(4): reg_write, mem_to_reg, reg_dst=0 -> FETCH.
  - MEMWR(5): mem_write, iord=1. Waits on mem_ready, then -> FETCH.
  - RTEXE(6): alu_src_a=1, alu_src_b=0, alu_op=100 -> RTWB.
  - RTWB(7): reg_write, reg_dst=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_op=001, pc_write_cond, pc_src=1, bne=(opcode_q==BNE) -> FETCH.
  - JUMP(9): pc_write, pc_src=2, jal=(opcode_q==JAL), reg_write=(opcode_q==JAL) -> FETCH.
  - IMMEXE(10): alu_src_a=1, alu_src_b=2, alu_op per opcode: ADDI 000, SLTI 010, ANDI 011, ORI 101, LI 111 -> IMMWB.
  - IMMWB(11): reg_write, reg_dst=0 -> FETCH.
  - SHIFTEXE(12): shift, sll=(opcode_q==SLL), alu_src_a=1 -> RTWB.
- Latency with mem_ready tied 1: LW 5 cycles; SW, R-type, immediate and shift 4; BEQ/BNE/J/JAL 3. Each wait cycle adds 1.
- instr_count wraps modulo 2^COUNT_W. It increments by 1 on every transition into FETCH from a non-FETCH state, DECODE-NOP included. It does not increment on FETCH wait cycles.
- mem_read/mem_write are held stable throughout waits.
- Reset mid-instruction aborts it immediately; no partial write is asserted after reset asserts.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP(13). TRAP asserts trap=1 with all write/request outputs 0, holds until reset, and does not increment instr_count.
- Undefined: TRAP is absent, unknown opcodes are NOPs, and trap is tied 0.

Decomposition:
- Package mc_pkg: opcode localparams, state encoding, alu_op encodings, pc_src and alu_src_b encodings.
- Sub-module mc_aluop_decode: combinational map opcode_q plus state to alu_op. It is shared with the single-cycle decoder's encoding.

Test Plan:
- Reset asserted in MEMWR (mem_ready=0) -> state=0, mem_write=0 immediately, instr_count=0.
- LW opcode 0x23, mem_ready=1 -> states 0,1,2,3,4,0; mem_to_reg=1 and reg_write=1 in state 4 only; instr_count +1.
- SW with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, iord=1; total 7 cycles.
- BNE 0x05 -> states 0,1,8; in state 8 pc_write_cond=1, bne=1, alu_op=001. JAL 0x03 -> state 9 with pc_src=2, jal=1, reg_write=1.
- ORI 0x0d -> IMMEXE alu_op=101; SLL 0x07 -> state 12 with shift=1, sll=1, then RTWB reg_dst=1.
- Opcode 0x3f -> without the macro, returns to FETCH and instr_count +1; with the macro, state=13, trap=1 and held, instr_count unchanged.
